// File: rtl/branch_compare_seq.sv
`default_nettype none
// ============================================================================
// Module   : branch_compare_seq
// Purpose  : Multi-cycle RV32 branch-condition unit. Compares two WIDTH-bit
//            operands one byte per cycle (MSB byte first) through a single
//            8-bit comparator slice, with optional early exit on the first
//            unequal byte, and resolves the branch selected by funct3.
// Ports    : clk, rst_n          - clock, synchronous active-low reset
//            in_valid/in_ready   - request handshake (a, b, funct3)
//            out_valid/out_ready - result handshake, result held until taken
//            equal/greater/less  - one-hot relation of a vs b
//            taken               - branch condition true
//            illegal             - funct3 is 010 or 011
// Revision : 1.0 - initial release
// ============================================================================
module branch_compare_seq #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       funct3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             equal,
    output logic             greater,
    output logic             less,
    output logic             taken,
    output logic             illegal
);

    localparam int N    = WIDTH / 8;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] C_IDX_MSB = IDXW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [2:0]        f3_q;
    // First-difference capture, used when all slices are walked
    logic              found_q, fgt_q, flt_q;
    logic              equal_q, greater_q, less_q, taken_q, illegal_q;
    logic              out_valid_q;

    logic [7:0]        w_sa, w_sb;
    logic              w_signed, w_slice_sgn;
    logic              w_slice_ne, w_slice_lt, w_slice_gt;
    logic              w_any_ne, w_gt, w_lt, w_last;
    logic              w_eq_fin, w_gt_fin, w_lt_fin, w_taken;

    // Byte selection for the shared comparator slice
    always_comb begin
        w_sa = '0;
        w_sb = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDXW'(i)) begin
                w_sa = a_q[8*i +: 8];
                w_sb = b_q[8*i +: 8];
            end
        end
    end

    // BLT/BGE are the only signed compares; only the MSB byte carries sign
    assign w_signed    = (f3_q[2:1] == 2'b10);
    assign w_slice_sgn = w_signed & (idx_q == C_IDX_MSB);
    assign w_slice_ne  = (w_sa != w_sb);
    assign w_slice_lt  = w_slice_sgn ? ($signed(w_sa) < $signed(w_sb)) : (w_sa < w_sb);
    assign w_slice_gt  = w_slice_ne & ~w_slice_lt;

    // An earlier captured difference always dominates the current slice
    assign w_any_ne = found_q | w_slice_ne;
    assign w_gt     = found_q ? fgt_q : w_slice_gt;
    assign w_lt     = found_q ? flt_q : w_slice_lt;
    assign w_last   = (idx_q == '0) | (EARLY_EXIT & w_slice_ne);

    assign w_eq_fin = ~w_any_ne;
    assign w_gt_fin = w_any_ne & w_gt;
    assign w_lt_fin = w_any_ne & w_lt;

    always_comb begin
        w_taken = 1'b0;
        case (f3_q)
            3'b000:         w_taken = w_eq_fin;
            3'b001:         w_taken = ~w_eq_fin;
            3'b100, 3'b110: w_taken = w_lt_fin;
            3'b101, 3'b111: w_taken = ~w_lt_fin;
            default:        w_taken = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_CMP;
            S_CMP:   if (w_last) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            f3_q        <= '0;
            found_q     <= 1'b0;
            fgt_q       <= 1'b0;
            flt_q       <= 1'b0;
            equal_q     <= 1'b0;
            greater_q   <= 1'b0;
            less_q      <= 1'b0;
            taken_q     <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        f3_q    <= funct3;
                        idx_q   <= C_IDX_MSB;
                        found_q <= 1'b0;
                    end
                end
                S_CMP: begin
                    if (w_last) begin
                        equal_q     <= w_eq_fin;
                        greater_q   <= w_gt_fin;
                        less_q      <= w_lt_fin;
                        taken_q     <= w_taken;
                        illegal_q   <= (f3_q[2:1] == 2'b01);
                        out_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                        if (!found_q && w_slice_ne) begin
                            found_q <= 1'b1;
                            fgt_q   <= w_slice_gt;
                            flt_q   <= w_slice_lt;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE) & rst_n;
    assign out_valid = out_valid_q;
    assign equal     = equal_q;
    assign greater   = greater_q;
    assign less      = less_q;
    assign taken     = taken_q;
    assign illegal   = illegal_q;

endmodule
`default_nettype wire
